// File: rtl/div_sign_ctrl.sv
// Signed/unsigned front-end for the M-extension divide path: resolves divide-by-zero
// and overflow locally, otherwise drives the unsigned divider and sign-corrects its result.
module div_sign_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            div_valid,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_data_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_data_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state, state_d;
  logic            rem_sel, rem_sel_d;
  logic            neg_q, neg_q_d;
  logic            neg_r, neg_r_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] result_d, dvd_d, dvs_d;
  logic            busy_d, result_valid_d, div_data_valid_d;

  logic            is_signed_c;
  logic            div_by_zero_c;
  logic            overflow_c;
  logic [XLEN-1:0] mag1_c, mag2_c;

  // Operand classification at acceptance
  always_comb begin
    is_signed_c   = ~op[0];
    div_by_zero_c = (rs2 == '0);
    overflow_c    = is_signed_c && (rs1 == MIN_NEG) && (rs2 == '1);
    mag1_c        = (is_signed_c && rs1[XLEN-1]) ? (~rs1 + XLEN'(1)) : rs1;
    mag2_c        = (is_signed_c && rs2[XLEN-1]) ? (~rs2 + XLEN'(1)) : rs2;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state;
    rem_sel_d = rem_sel;
    neg_q_d   = neg_q;
    neg_r_d   = neg_r;
    rd_d      = rd_out;
    result_d  = result;
    dvd_d     = div_dividend;
    dvs_d     = div_divisor;

    case (state)
      IDLE: begin
        if (div_valid) begin
          rem_sel_d = op[1];
          neg_q_d   = is_signed_c & (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_r_d   = is_signed_c & rs1[XLEN-1];
          rd_d      = rd_in;
          if (div_by_zero_c) begin
            result_d = op[1] ? rs1 : '1;
            state_d  = DONE;
          end else if (overflow_c) begin
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            dvd_d   = mag1_c;
            dvs_d   = mag2_c;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_data_ready) begin
          if (rem_sel) begin
            result_d = neg_r ? (~div_remainder + XLEN'(1)) : div_remainder;
          end else begin
            result_d = neg_q ? (~div_quotient + XLEN'(1)) : div_quotient;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d           = (state_d != IDLE);
    result_valid_d   = (state_d == DONE);
    div_data_valid_d = (state_d == ISSUE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem_sel        <= 1'b0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      rd_out         <= '0;
      result         <= '0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      div_data_valid <= 1'b0;
    end else begin
      state          <= state_d;
      rem_sel        <= rem_sel_d;
      neg_q          <= neg_q_d;
      neg_r          <= neg_r_d;
      rd_out         <= rd_d;
      result         <= result_d;
      div_dividend   <= dvd_d;
      div_divisor    <= dvs_d;
      busy           <= busy_d;
      result_valid   <= result_valid_d;
      div_data_valid <= div_data_valid_d;
    end
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl with a hand-fed divider response.
module tb_div_sign_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        div_valid;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        busy, result_valid, div_data_valid;
  logic [31:0] result, div_dividend, div_divisor;
  logic [4:0]  rd_out;
  logic [31:0] div_quotient, div_remainder;
  logic        div_data_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  div_sign_ctrl #(.XLEN(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .div_valid(div_valid), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .busy(busy), .result_valid(result_valid), .result(result),
    .rd_out(rd_out), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_data_valid(div_data_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_data_ready(div_data_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One operation; called #1 after a rising edge with the DUT in IDLE.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input bit special,
                     input logic [31:0] dvd, input logic [31:0] dvs,
                     input logic [31:0] q, input logic [31:0] r,
                     input logic [31:0] exp, input bit poke);
    div_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = rd;
    tick();
    div_valid = 1'b0;
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    if (special) begin
      chk({tag, ".rv"}, 32'(result_valid), 32'd1);
      chk({tag, ".res"}, result, exp);
      chk({tag, ".rd"}, 32'(rd_out), 32'(rd));
      chk({tag, ".ddv"}, 32'(div_data_valid), 32'd0);
    end else begin
      chk({tag, ".ddv"}, 32'(div_data_valid), 32'd1);
      chk({tag, ".rv0"}, 32'(result_valid), 32'd0);
      chk({tag, ".dvd"}, div_dividend, dvd);
      chk({tag, ".dvs"}, div_divisor, dvs);
      tick();
      chk({tag, ".ddv_wait"}, 32'(div_data_valid), 32'd0);
      if (poke) begin
        div_valid = 1'b1; op = 2'b00; rs1 = 32'd1; rs2 = 32'd0; rd_in = 5'd3;
      end
      tick();
      div_valid = 1'b0;
      chk({tag, ".busy_wait"}, 32'(busy), 32'd1);
      chk({tag, ".rv_wait"}, 32'(result_valid), 32'd0);
      tick();
      chk({tag, ".dvd_hold"}, div_dividend, dvd);
      div_data_ready = 1'b1; div_quotient = q; div_remainder = r;
      tick();
      div_data_ready = 1'b0; div_quotient = 32'hDEAD_BEEF; div_remainder = 32'hDEAD_BEEF;
      chk({tag, ".rv"}, 32'(result_valid), 32'd1);
      chk({tag, ".res"}, result, exp);
      chk({tag, ".rd"}, 32'(rd_out), 32'(rd));
    end
    tick();
    chk({tag, ".rv_end"}, 32'(result_valid), 32'd0);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".res_hold"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; div_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    div_quotient = '0; div_remainder = '0; div_data_ready = 1'b0;
    tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rv", 32'(result_valid), 32'd0);
    chk("rst.ddv", 32'(div_data_valid), 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.rd", 32'(rd_out), 32'd0);
    chk("rst.dvd", div_dividend, 32'd0);
    chk("rst.dvs", div_divisor, 32'd0);
    rst_n = 1'b1;
    tick();

    //   tag        op     rs1           rs2           rd  sp  dvd           dvs           q             r             expected      poke
    run("div_m7_2",  2'b00, 32'hFFFFFFF9, 32'd2,        5'd1, 0, 32'd7,        32'd2,        32'd3,        32'd1,        32'hFFFFFFFD, 0);
    run("rem_m7_2",  2'b10, 32'hFFFFFFF9, 32'd2,        5'd2, 0, 32'd7,        32'd2,        32'd3,        32'd1,        32'hFFFFFFFF, 0);
    run("rem_7_m2",  2'b10, 32'd7,        32'hFFFFFFFE, 5'd4, 0, 32'd7,        32'd2,        32'd3,        32'd1,        32'd1,        0);
    run("divu_big",  2'b01, 32'hFFFFFFFE, 32'd2,        5'd5, 0, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 0);
    run("remu_100",  2'b11, 32'd100,      32'd7,        5'd17,0, 32'd100,      32'd7,        32'd14,       32'd2,        32'd2,        1);

    // Spurious divider completion while idle must be ignored
    div_data_ready = 1'b1; div_quotient = 32'h1234; div_remainder = 32'h5678;
    tick();
    div_data_ready = 1'b0;
    tick();
    chk("spur.busy", 32'(busy), 32'd0);
    chk("spur.rv", 32'(result_valid), 32'd0);
    chk("spur.res", result, 32'd2);

    run("div_min_2", 2'b00, 32'h80000000, 32'd2,        5'd6, 0, 32'h80000000, 32'd2,        32'h40000000, 32'd0,        32'hC0000000, 0);
    run("div_by0",   2'b00, 32'd5,        32'd0,        5'd7, 1, 32'd0,        32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 0);
    run("rem_by0",   2'b10, 32'd5,        32'd0,        5'd8, 1, 32'd0,        32'd0,        32'd0,        32'd0,        32'd5,        0);
    run("div_ovf",   2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1, 32'd0,        32'd0,        32'd0,        32'd0,        32'h80000000, 0);
    run("rem_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd10,1, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        0);
    run("divu_ovf",  2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd11,0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 32'd0,        0);
    run("div_seed",  2'b00, 32'd9,        32'd2,        5'd12,0, 32'd9,        32'd2,        32'd4,        32'd1,        32'd4,        0);

    // Reset asserted while waiting on the divider
    div_valid = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd4; rd_in = 5'd13;
    tick();
    div_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.res", result, 32'd0);
    chk("mid.rd", 32'(rd_out), 32'd0);
    chk("mid.dvd", div_dividend, 32'd0);
    chk("mid.dvs", div_divisor, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid.rv", 32'(result_valid), 32'd0);
    chk("mid.busy2", 32'(busy), 32'd0);

    run("div_20_m3", 2'b00, 32'd20,       32'hFFFFFFFD, 5'd14,0, 32'd20,       32'd3,        32'd6,        32'd2,        32'hFFFFFFFA, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
